// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment scan driver.
package seven_seg_pkg;

   localparam int NUM_DIGITS = 8;

   // Bit positions inside the active-high {dp,g,f,e,d,c,b,a} segment byte
   localparam int SEG_A  = 0;
   localparam int SEG_G  = 6;
   localparam int SEG_DP = 7;

   // Hex glyphs, active high, bit 0 = segment a. Entry 0 is the rightmost element.
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
      7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   // Power-up test pattern shown until the first committed load
   localparam logic [31:0] RESET_WORD = 32'hAA5555AA;

   typedef enum logic {BLANK, DRIVE} slot_state_t;

endpackage

// File: rtl/seven_seg_scan_drv_if.sv
// Display-word load bus between the display-select logic (master) and the
// scan driver (slave). Optional blink_mask exists only when SEG_BLINK_EN is defined.
interface seven_seg_scan_drv_if;
   import seven_seg_pkg::*;

   logic [31:0]           disp_num;
   logic [NUM_DIGITS-1:0] disp_point;
   logic                  disp_ld;
   logic                  ld_ack;
`ifdef SEG_BLINK_EN
   logic [NUM_DIGITS-1:0] blink_mask;

   modport master (output disp_num, disp_point, disp_ld, blink_mask, input ld_ack);
   modport slave  (input disp_num, disp_point, disp_ld, blink_mask, output ld_ack);
`else
   modport master (output disp_num, disp_point, disp_ld, input ld_ack);
   modport slave  (input disp_num, disp_point, disp_ld, output ld_ack);
`endif

endinterface

// File: rtl/seven_seg_hex_decode.sv
// Combinational nibble + decimal point -> active-high {dp,g,f,e,d,c,b,a}.
module seven_seg_hex_decode
   import seven_seg_pkg::*;
(
   input  logic [3:0] nib,
   input  logic       dp,
   output logic [7:0] seg
);

   // Table lookup for the glyph, decimal point passed straight through
   always_comb begin
      seg              = '0;
      seg[SEG_G:SEG_A] = HEX_SEG[nib];
      seg[SEG_DP]      = dp;
   end

endmodule

// File: rtl/seven_seg_scan_drv.sv
// Seven-segment scan driver: commits the display word tear-free at frame
// wrap and multiplexes 8 hex digits onto a panel, with a blank slot before
// each digit to suppress ghosting.
// Optional feature macro: SEG_BLINK_EN (adds blink_mask and a frame counter).
module seven_seg_scan_drv
   import seven_seg_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit AN_ACTIVE_LOW  = 1'b1,
   parameter int BLINK_DIV_W    = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   seven_seg_scan_drv_if.slave   bus,
   output logic [NUM_DIGITS-1:0] seg_an,
   output logic [7:0]            seg_out,
   output logic                  frame_done
);

   localparam int DIV_W = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
   localparam int DIG_W = $clog2(NUM_DIGITS);

   // Pin-level "off" patterns; XOR with these applies polarity last
   localparam logic [7:0]            SEG_OFF = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW  ? '1    : '0;

   generate
      if (SCAN_DIV < 2) begin : g_bad_div
         $error("SCAN_DIV must be >= 2");
      end
      if (BLINK_DIV_W < 1) begin : g_bad_blink
         $error("BLINK_DIV_W must be >= 1");
      end
   endgenerate

   logic [DIV_W-1:0]      div;
   logic [DIG_W-1:0]      digit;
   slot_state_t           state;
   logic [31:0]           shadow_num, pend_num;
   logic [NUM_DIGITS-1:0] shadow_pt, pend_pt;
   logic                  pend;
   logic                  ld_ack_r;
   logic                  div_tc, wrap;
   logic [7:0]            seg_ah;
   logic                  blank_dig;

   assign div_tc     = (div == DIV_W'(SCAN_DIV - 1));
   assign wrap       = div_tc && (digit == DIG_W'(NUM_DIGITS - 1));
   assign bus.ld_ack = ld_ack_r;

   seven_seg_hex_decode u_dec (
      .nib (shadow_num[digit*4 +: 4]),
      .dp  (shadow_pt[digit]),
      .seg (seg_ah)
   );

`ifdef SEG_BLINK_EN
   logic [BLINK_DIV_W:0] frame_cnt;

   // Frame counter; its MSB is the blink phase
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)      frame_cnt <= '0;
      else if (wrap) frame_cnt <= frame_cnt + 1'b1;
   end

   assign blank_dig = frame_cnt[BLINK_DIV_W] & bus.blink_mask[digit];
`else
   assign blank_dig = 1'b0;
`endif

   // Slot divider and digit index; digit wraps 7 -> 0 by width
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div   <= '0;
         digit <= '0;
      end else if (div_tc) begin
         div   <= '0;
         digit <= digit + 1'b1;
      end else begin
         div   <= div + 1'b1;
      end
   end

   // Slot FSM with registered pin outputs; BLANK covers divider==0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= BLANK;
         seg_an  <= AN_OFF;
         seg_out <= SEG_OFF;
      end else begin
         case (state)
            BLANK: begin
               seg_an  <= AN_OFF;
               seg_out <= SEG_OFF;
               state   <= DRIVE;
            end
            DRIVE: begin
               seg_an  <= (NUM_DIGITS'(1) << digit) ^ AN_OFF;
               seg_out <= blank_dig ? SEG_OFF : (seg_ah ^ SEG_OFF);
               if (div_tc) state <= BLANK;
            end
            default: state <= BLANK;
         endcase
      end
   end

   // Pending/shadow registers: loads park in pending, commit only at frame wrap;
   // a load in the wrap cycle itself bypasses pending
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shadow_num <= RESET_WORD;
         shadow_pt  <= '0;
         pend_num   <= '0;
         pend_pt    <= '0;
         pend       <= 1'b0;
         frame_done <= 1'b0;
         ld_ack_r   <= 1'b0;
      end else begin
         frame_done <= wrap;
         ld_ack_r   <= 1'b0;
         if (wrap) begin
            if (bus.disp_ld) begin
               shadow_num <= bus.disp_num;
               shadow_pt  <= bus.disp_point;
               ld_ack_r   <= 1'b1;
            end else if (pend) begin
               shadow_num <= pend_num;
               shadow_pt  <= pend_pt;
               ld_ack_r   <= 1'b1;
            end
            pend <= 1'b0;
         end else if (bus.disp_ld) begin
            pend_num <= bus.disp_num;
            pend_pt  <= bus.disp_point;
            pend     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_scan_drv.sv
// Scoreboard bench for seven_seg_scan_drv (SCAN_DIV=4). The stimulus side
// predicts each cycle's pin state from a cycle-count model and queues it;
// a negedge monitor pops and compares.
module tb_seven_seg_scan_drv;

   localparam int S = 4;
   localparam int FRAME = 8 * S;
`ifdef SEG_BLINK_EN
   localparam int BW = 1;
`else
   localparam int BW = 4;
`endif

   typedef struct packed {
      logic [7:0] an;
      logic [7:0] seg;
      logic       fd;
      logic       ack;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] seg_an, seg_out;
   logic       frame_done;

   seven_seg_scan_drv_if dif ();

   seven_seg_scan_drv #(
      .SCAN_DIV       (S),
      .SEG_ACTIVE_LOW (1'b1),
      .AN_ACTIVE_LOW  (1'b1),
      .BLINK_DIV_W    (BW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (dif.slave),
      .seg_an     (seg_an),
      .seg_out    (seg_out),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   exp_t q[$];
   int   vectors = 0;
   int   errors  = 0;

   // Reference model state
   int          t;
   logic [31:0] m_num, p_num;
   logic [7:0]  m_pt, p_pt;
   bit          m_pend;

   // Standard hex font, active high, bit0 = a
   function automatic logic [6:0] font(input logic [3:0] n);
      case (n)
         4'h0: font = 7'h3F; 4'h1: font = 7'h06; 4'h2: font = 7'h5B; 4'h3: font = 7'h4F;
         4'h4: font = 7'h66; 4'h5: font = 7'h6D; 4'h6: font = 7'h7D; 4'h7: font = 7'h07;
         4'h8: font = 7'h7F; 4'h9: font = 7'h6F; 4'hA: font = 7'h77; 4'hB: font = 7'h7C;
         4'hC: font = 7'h39; 4'hD: font = 7'h5E; 4'hE: font = 7'h79; default: font = 7'h71;
      endcase
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      vectors++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic model_reset();
      t      = 0;
      m_num  = 32'hAA5555AA;
      m_pt   = 8'h00;
      m_pend = 1'b0;
      p_num  = '0;
      p_pt   = '0;
   endtask

   // One clock: apply inputs, predict the pins after this edge, queue it
   task automatic cyc(input bit ld, input logic [31:0] num, input logic [7:0] pt);
      exp_t       e;
      int         slot, dg, fr;
      logic [7:0] ah;
      dif.disp_ld    = ld;
      dif.disp_num   = num;
      dif.disp_point = pt;
      slot = t % S;
      dg   = (t / S) % 8;
      fr   = t / FRAME;
      if (slot == 0) begin
         e.an  = 8'hFF;
         e.seg = 8'hFF;
      end else begin
         e.an = ~(8'd1 << dg);
         ah   = {m_pt[dg], font(m_num[dg*4 +: 4])};
`ifdef SEG_BLINK_EN
         if (((fr >> BW) & 1) == 1 && dif.blink_mask[dg]) ah = 8'h00;
`endif
         e.seg = ~ah;
      end
      e.fd  = (t % FRAME) == FRAME - 1;
      e.ack = 1'b0;
      if (e.fd) begin
         if (ld) begin
            m_num = num; m_pt = pt; e.ack = 1'b1;
         end else if (m_pend) begin
            m_num = p_num; m_pt = p_pt; e.ack = 1'b1;
         end
         m_pend = 1'b0;
      end else if (ld) begin
         p_num = num; p_pt = pt; m_pend = 1'b1;
      end
      @(posedge clk);
      q.push_back(e);
      t++;
      #1;
      dif.disp_ld = 1'b0;
      if (fr < 0) $display("unreachable");
   endtask

   task automatic idle();
      cyc(1'b0, 32'h0, 8'h0);
   endtask

   // Idle until the next edge to be issued sits at position pos of a frame
   task automatic run_to(input int pos);
      while ((t % FRAME) != pos) idle();
   endtask

   // Monitor: compare every post-reset cycle against the queued prediction
   always @(negedge clk) begin
      exp_t e;
      if (rst && q.size() > 0) begin
         e = q.pop_front();
         vectors++;
         if ({seg_an, seg_out, frame_done, dif.ld_ack} !== e) begin
            errors++;
            $display("FAIL scan: got an=%h seg=%h fd=%b ack=%b, expected an=%h seg=%h fd=%b ack=%b",
                     seg_an, seg_out, frame_done, dif.ld_ack, e.an, e.seg, e.fd, e.ack);
         end
      end
   end

   initial begin
      dif.disp_ld    = 1'b0;
      dif.disp_num   = '0;
      dif.disp_point = '0;
`ifdef SEG_BLINK_EN
      dif.blink_mask = 8'h00;
`endif
      model_reset();
      #1 rst = 1'b0;
      #20;
      chk("reset_an",  seg_an, 8'hFF);
      chk("reset_seg", seg_out, 8'hFF);
      chk("reset_fd_ack", {6'b0, frame_done, dif.ld_ack}, 8'h00);
      @(posedge clk); #1;
      rst = 1'b1;

      // Power-up pattern
      idle(); idle();
      chk("first_digit0_an",  seg_an, 8'hFE);
      chk("first_digit0_seg", seg_out, 8'h88);
      run_to(2 * S + 1); idle();
      chk("digit2_five", seg_out, 8'h92);

      // Load mid-frame, visible only after wrap
      run_to(3 * S + 1); cyc(1'b1, 32'h12345678, 8'h00);
      run_to(1); idle();
      chk("load_digit0", seg_out, 8'h80);

      // Two loads in one frame: last wins
      run_to(2 * S); cyc(1'b1, 32'h11111111, 8'h00);
      run_to(5 * S); cyc(1'b1, 32'h22222222, 8'h00);
      run_to(1); idle();
      chk("last_wins_digit0", seg_out, 8'hA4);

      // Load in the wrap cycle bypasses pending
      run_to(FRAME - 1); cyc(1'b1, 32'h0000000F, 8'h00);
      idle(); idle();
      chk("bypass_digit0", seg_out, 8'h8E);

`ifdef SEG_BLINK_EN
      dif.blink_mask = 8'h01;
      run_to(0);
      repeat (5 * FRAME) idle();
`endif

      // Randomized loads and points
      for (int f = 0; f < 30; f++) begin
`ifdef SEG_BLINK_EN
         dif.blink_mask = 8'($urandom);
`endif
         for (int c = 0; c < FRAME; c++) begin
            if ($urandom_range(0, 11) == 0) cyc(1'b1, $urandom, 8'($urandom));
            else idle();
         end
      end

      // Async reset during digit 5 drive
      run_to(5 * S + 2); idle();
      rst = 1'b0;
      q.delete();
      #1;
      chk("midreset_an",  seg_an, 8'hFF);
      chk("midreset_seg", seg_out, 8'hFF);
      chk("midreset_fd_ack", {6'b0, frame_done, dif.ld_ack}, 8'h00);
`ifdef SEG_BLINK_EN
      dif.blink_mask = 8'h00;
`endif
      @(posedge clk); #1;
      model_reset();
      rst = 1'b1;
      idle(); idle();
      chk("postreset_an",  seg_an, 8'hFE);
      chk("postreset_seg", seg_out, 8'h88);
      repeat (FRAME) idle();

      @(negedge clk); @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
